// File: rtl/qpsk_symbol_mapper_if.sv
// Handshake bundle between a serial bit source, the QPSK symbol mapper and the
// pulse-shaping/DAC sink. The mapper uses the slave view, its environment the master view.
interface qpsk_symbol_mapper_if;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_last;
  logic               bit_ready;
  logic signed [15:0] sym_re;
  logic signed [15:0] sym_im;
  logic               sym_valid;
  logic               sym_last;
  logic               sym_padded;
  logic               sym_ready;

  modport master (
    output bit_in, bit_valid, bit_last, sym_ready,
    input  bit_ready, sym_re, sym_im, sym_valid, sym_last, sym_padded
  );

  modport slave (
    input  bit_in, bit_valid, bit_last, sym_ready,
    output bit_ready, sym_re, sym_im, sym_valid, sym_last, sym_padded
  );
endinterface

// File: rtl/qpsk_symbol_mapper.sv
// QPSK transmit mapper: pairs serial bits (odd first), maps each pair to a signed
// En13 I/Q symbol and buffers symbols in a 2-entry FIFO toward the DAC path.
module qpsk_symbol_mapper #(
  parameter logic signed [15:0] AMP     = 16'sd5793,
  parameter logic               PAD_BIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qpsk_symbol_mapper_if.slave  bus
);

  typedef enum logic {
    WAIT_ODD,
    WAIT_EVEN
  } pair_state_e;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               last;
    logic               padded;
  } sym_entry_t;

  localparam logic signed [15:0] AMP_NEG = 16'sd0 - AMP;

  pair_state_e state_q, state_d;
  logic        odd_q, odd_d;
  sym_entry_t  fifo_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        full;
  logic        bit_fire;
  logic        sym_fire;
  logic        push;
  logic        push_odd;
  logic        push_even;
  logic        push_last;
  logic        push_padded;
  sym_entry_t  push_entry;

  // Ready depends only on registered occupancy, so sym_ready never reaches bit_ready.
  assign full     = (count_q == 2'd2);
  assign bit_fire = bus.bit_valid && !full;
  assign sym_fire = bus.sym_ready && (count_q != 2'd0);

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    odd_d       = odd_q;
    push        = 1'b0;
    push_odd    = odd_q;
    push_even   = bus.bit_in;
    push_last   = 1'b0;
    push_padded = 1'b0;

    if (bit_fire) begin
      unique case (state_q)
        WAIT_ODD: begin
          if (bus.bit_last) begin
            push        = 1'b1;
            push_odd    = bus.bit_in;
            push_even   = PAD_BIT;
            push_last   = 1'b1;
            push_padded = 1'b1;
          end else begin
            odd_d   = bus.bit_in;
            state_d = WAIT_EVEN;
          end
        end
        WAIT_EVEN: begin
          push      = 1'b1;
          push_odd  = odd_q;
          push_even = bus.bit_in;
          push_last = bus.bit_last;
          state_d   = WAIT_ODD;
        end
        default: state_d = WAIT_ODD;
      endcase
    end

    push_entry.re     = push_odd  ? AMP : AMP_NEG;
    push_entry.im     = push_even ? AMP : AMP_NEG;
    push_entry.last   = push_last;
    push_entry.padded = push_padded;

    wr_ptr_d = push     ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = sym_fire ? ~rd_ptr_q : rd_ptr_q;

    unique case ({push, sym_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_ODD;
      odd_q    <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      // NOTE: the storage is reset because the head entry drives the symbol outputs,
      // which must read zero out of reset.
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      odd_q    <= odd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= push_entry;
      end
    end
  end

  assign bus.bit_ready  = !full;
  assign bus.sym_valid  = (count_q != 2'd0);
  assign bus.sym_re     = fifo_q[rd_ptr_q].re;
  assign bus.sym_im     = fifo_q[rd_ptr_q].im;
  assign bus.sym_last   = fifo_q[rd_ptr_q].last;
  assign bus.sym_padded = fifo_q[rd_ptr_q].padded;

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Scoreboard bench for qpsk_symbol_mapper: a reference pairing model queues expected
// symbols on each accepted bit; they are compared as the DUT hands symbols out.
module tb_qpsk_symbol_mapper;

  localparam logic [15:0] POS = 16'h16A1;
  localparam logic [15:0] NEG = 16'hE95F;

  typedef struct {
    logic odd;
    logic even;
    logic last;
    logic padded;
  } exp_t;

  logic clk;
  logic rst_n;

  qpsk_symbol_mapper_if bus ();

  qpsk_symbol_mapper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   total;
  int   bad;
  exp_t exp_q [$];
  logic pend;
  logic pend_odd;
  int   cyc;
  int   bits_acc;
  int   rx_cnt;
  logic track;
  int   last_xfer;
  int   stalls;
  int   gaps;

  logic        s_valid;
  logic        s_last;
  logic        s_pad;
  logic        s_bit_ready;
  logic        s_bit_fire;
  logic [15:0] s_re;
  logic [15:0] s_im;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] amp_of(input logic b);
    return b ? POS : NEG;
  endfunction

  // One clock: sample and score at the falling edge, return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    s_valid     = bus.sym_valid;
    s_last      = bus.sym_last;
    s_pad       = bus.sym_padded;
    s_re        = bus.sym_re;
    s_im        = bus.sym_im;
    s_bit_ready = bus.bit_ready;
    s_bit_fire  = rst_n && bus.bit_valid && bus.bit_ready;
    if (!rst_n) begin
      exp_q.delete();
      pend = 1'b0;
    end else begin
      if (track && bus.bit_valid && !bus.bit_ready) stalls++;
      if (s_bit_fire) begin
        bits_acc++;
        if (!pend) begin
          if (bus.bit_last) begin
            e = '{odd: bus.bit_in, even: 1'b0, last: 1'b1, padded: 1'b1};
            exp_q.push_back(e);
          end else begin
            pend     = 1'b1;
            pend_odd = bus.bit_in;
          end
        end else begin
          e = '{odd: pend_odd, even: bus.bit_in, last: bus.bit_last, padded: 1'b0};
          exp_q.push_back(e);
          pend = 1'b0;
        end
      end
      if (bus.sym_valid && bus.sym_ready) begin
        rx_cnt++;
        if (track) begin
          if (last_xfer >= 0 && (cyc - last_xfer) != 2) gaps++;
          last_xfer = cyc;
        end
        if (exp_q.size() == 0) begin
          check("extra_sym", 16'd1, 16'd0);
        end else begin
          e = exp_q.pop_front();
          check("sym_re", bus.sym_re, amp_of(e.odd));
          check("sym_im", bus.sym_im, amp_of(e.even));
          check("sym_last", {15'd0, bus.sym_last}, {15'd0, e.last});
          check("sym_padded", {15'd0, bus.sym_padded}, {15'd0, e.padded});
          check("demod_odd", {15'd0, ~bus.sym_re[15]}, {15'd0, e.odd});
          if (!e.padded) check("demod_even", {15'd0, ~bus.sym_im[15]}, {15'd0, e.even});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic last);
    bus.bit_in    = b;
    bus.bit_last  = last;
    bus.bit_valid = 1'b1;
    s_bit_fire    = 1'b0;
    for (int n = 0; n < 100 && !s_bit_fire; n++) tick();
    if (!s_bit_fire) check("bit_accept_timeout", 16'd0, 16'd1);
  endtask

  task automatic idle();
    bus.bit_valid = 1'b0;
    bus.bit_last  = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
    check("drain_empty", 16'(exp_q.size()), 16'd0);
  endtask

  int acc_before;
  int rx_before;

  initial begin
    total = 0; bad = 0; cyc = 0; bits_acc = 0; rx_cnt = 0;
    pend = 1'b0; pend_odd = 1'b0; track = 1'b0; last_xfer = -1; stalls = 0; gaps = 0;
    rst_n         = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_last  = 1'b0;
    bus.sym_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_valid", {15'd0, s_valid}, 16'd0);
    check("rst_re", s_re, 16'd0);
    check("rst_im", s_im, 16'd0);
    check("rst_last", {15'd0, s_last}, 16'd0);
    check("rst_padded", {15'd0, s_pad}, 16'd0);
    check("rst_bit_ready", {15'd0, s_bit_ready}, 16'd1);

    // First symbol appears one cycle after the second accept.
    bus.sym_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    idle();
    tick();
    check("lat_valid", {15'd0, s_valid}, 16'd1);
    check("lat_re", s_re, POS);
    check("lat_im", s_im, POS);
    check("lat_padded", {15'd0, s_pad}, 16'd0);

    // Remaining bit-pair patterns.
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    idle();
    drain();

    // Backpressure: two buffered symbols, fifth bit stalls, head holds.
    bus.sym_ready = 1'b0;
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    idle();
    tick();
    check("full_bit_ready", {15'd0, s_bit_ready}, 16'd0);
    acc_before    = bits_acc;
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    repeat (3) begin
      tick();
      check("stall_bit_ready", {15'd0, s_bit_ready}, 16'd0);
      check("stall_valid", {15'd0, s_valid}, 16'd1);
      check("stall_re", s_re, POS);
      check("stall_im", s_im, NEG);
    end
    check("stall_no_accept", 16'(bits_acc - acc_before), 16'd0);
    bus.sym_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    idle();
    drain();

    // Odd-length frame gets a padded last symbol; next bit is odd again.
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    idle();
    drain();

    // Asynchronous reset with a pending odd bit and a buffered symbol.
    bus.sym_ready = 1'b0;
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    idle();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {15'd0, bus.sym_valid}, 16'd0);
    check("async_rst_bit_ready", {15'd0, bus.bit_ready}, 16'd1);
    repeat (2) tick();
    rst_n         = 1'b1;
    rx_before     = rx_cnt;
    bus.sym_ready = 1'b1;
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    idle();
    drain();
    repeat (3) tick();
    check("post_rst_sym_count", 16'(rx_cnt - rx_before), 16'd1);

    // Full-rate random stream.
    track         = 1'b1;
    last_xfer     = -1;
    rx_before     = rx_cnt;
    acc_before    = bits_acc;
    bus.sym_ready = 1'b1;
    bus.bit_last  = 1'b0;
    bus.bit_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus.bit_in = 1'($urandom);
      tick();
    end
    idle();
    drain();
    track = 1'b0;
    check("rand_bits", 16'(bits_acc - acc_before), 16'd1000);
    check("rand_syms", 16'(rx_cnt - rx_before), 16'd500);
    check("rand_stalls", 16'(stalls), 16'd0);
    check("rand_gaps", 16'(gaps), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
